ace_video_timing: RTL and testbench
===================================

Name: ace_video_timing

Overview:
- Upstream stage of the scandoubler: derives the pixel-clock enable from clk_sys and produces the native 15 kHz raster for the Jupiter Ace.
- Outputs: ce_pix, ce_pix_actual, hs, vs, line_start, blanking/DE, beam counters and character-fetch addressing for the video RAM.
- All outputs feed the scandoubler inputs of the same names directly and are glitch-free registered signals in the clk_sys domain.

Parameters:
- CLK_DIV, 4, clk_sys cycles per pixel; range 2..16; 2 is the minimum so ce_pix always has a rising edge.
- PIX_REP, 0, 1 = ce_pix_actual only on even hcnt (pixel-doubled mode); 0 = ce_pix_actual equals ce_pix.
- H_TOTAL, 416, pixels per line.
- H_ACTIVE, 256, visible pixels, starting at hcnt=0.
- H_SYNC_START, 320, hcnt at which hs rises.
- H_SYNC_LEN, 32, hs width in pixels.
- V_TOTAL, 312, lines per frame.
- V_ACTIVE, 192, visible lines, starting at vcnt=0.
- V_SYNC_START, 248, vcnt at which vs rises.
- V_SYNC_LEN, 8, vs width in lines.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- ce_pix  out  1  one-clk pulse every CLK_DIV clocks.
- ce_pix_actual  out  1  qualifier for ce_pix, see PIX_REP.
- hs  out  1  horizontal sync, active high.
- vs  out  1  vertical sync, active high.
- line_start  out  1  high for the whole pixel period hcnt==H_TOTAL-1.
- hblank  out  1  hcnt>=H_ACTIVE.
- vblank  out  1  vcnt>=V_ACTIVE.
- de  out  1  ~hblank & ~vblank.
- hcnt  out  9  pixel counter.
- vcnt  out  9  line counter.
- fetch  out  1  one-clk pulse: character fetch request.
- char_addr  out  10  {vcnt[7:3], hcnt[7:3]}, 32x24 character map.
- char_row  out  3  vcnt[2:0].

Behaviour:
- Divider: div counts 0..CLK_DIV-1 and wraps. The ce_pix register is 1 for exactly the clock after div==CLK_DIV-1, and 0 otherwise.
- Counter advance: on each clock where the internal tick (div==CLK_DIV-1) is true:
  - hcnt increments; if hcnt==H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps from V_TOTAL-1 to 0.
- Output timing: all outputs are registered and updated on that same edge, so they are coincident with the new counter values and with ce_pix=1.
- hs = (hcnt>=H_SYNC_START) & (hcnt<H_SYNC_START+H_SYNC_LEN).
- vs = (vcnt>=V_SYNC_START) & (vcnt<V_SYNC_START+V_SYNC_LEN). vs changes only at the hcnt 0 transition.
- ce_pix_actual: equals ce_pix when PIX_REP=0. When PIX_REP=1 it is ce_pix & (new hcnt[0]==0). This gives the scandoubler a ce_div of 2.
- fetch: asserted with ce_pix when new hcnt[2:0]==0 & new hcnt<H_ACTIVE & new vcnt<V_ACTIVE. char_addr and char_row are valid in that cycle and hold until the next fetch. 32 fetches per active line, 6144 per frame.
- Reset (any clock, including mid-line or mid-sync): div=0, hcnt=0, vcnt=0, and all outputs 0 (ce_pix, ce_pix_actual, hs, vs, line_start, hblank, vblank, de, fetch, char_addr, char_row). Pixel (0,0) of the first frame is not flagged de. The first ce_pix appears CLK_DIV clocks after reset deasserts, with hcnt=1.
- Width rules: counters are 9 bits, so H_TOTAL and V_TOTAL must be <=512. Sync windows must lie inside the totals. Violations are flagged by an elaboration-time check (synthesis error), not by runtime logic.
- Sync behaviour at the boundaries:
  - hs and line_start never overlap with the defaults.
  - The scandoubler resets its line counter on the falling edge of vs; no vertical delay is added here.

Decomposition:
- Shared package ace_video_pkg holds the Ace raster constants (416/256/320/32, 312/192/248/8), the counter width (9) and the character map geometry (32x24, 8x8).
- Natural sub-module: ace_ce_gen (divider plus ce_pix/ce_pix_actual generation), reused by the audio and keyboard scan enables.
- The raster/fetch logic stays in the top block.

Test Plan:
- Reset then run with CLK_DIV=4: ce_pix one clock high in every 4. First ce_pix at clock 4 after reset release with hcnt=1. 416 ce_pix per line measured.
- hs: rises on the ce_pix where hcnt=320 and falls where hcnt=352 (32 pixels high). line_start is high only while hcnt=415. hblank rises at hcnt=256.
- Frame: vcnt wraps 311->0 coincident with hcnt 415->0. vs is high for vcnt 248..255 (8 lines). vblank covers 192..311. Frame length 129792 ce_pix.
- Fetch: line vcnt=13 yields 32 pulses at hcnt 0,8,...,248, with char_addr 0x020..0x03F and char_row=5. No fetch on vcnt>=192.
- PIX_REP=1: ce_pix_actual on even hcnt only (208 per line); ce_pix unchanged.
- Assert reset for 1 clock at hcnt=330 (inside hs): the next clock shows hs=0, hcnt=0, vcnt=0, ce_pix=0, and the timing restarts as in the first scenario.

Source files
------------

// File: rtl/ace_video_pkg.sv
// Jupiter Ace raster constants, counter widths and character map geometry.
// Shared by the video timing block, its interface and its enable generator.
package ace_video_pkg;
  localparam int CNT_W  = 9;
  localparam int ADDR_W = 10;
  localparam int ROW_W  = 3;

  localparam int ACE_H_TOTAL      = 416;
  localparam int ACE_H_ACTIVE     = 256;
  localparam int ACE_H_SYNC_START = 320;
  localparam int ACE_H_SYNC_LEN   = 32;
  localparam int ACE_V_TOTAL      = 312;
  localparam int ACE_V_ACTIVE     = 192;
  localparam int ACE_V_SYNC_START = 248;
  localparam int ACE_V_SYNC_LEN   = 8;

  localparam int CHAR_COLS = 32;
  localparam int CHAR_ROWS = 24;
  localparam int GLYPH_W   = 8;
  localparam int GLYPH_H   = 8;

  function automatic logic in_win(
    input logic [CNT_W:0] x,
    input logic [CNT_W:0] lo,
    input logic [CNT_W:0] hi
  );
    return (x >= lo) && (x < hi);
  endfunction
endpackage

// File: rtl/ace_video_if.sv
// Raster bundle from the timing generator to the scandoubler.
// master drives every signal, slave observes them.
interface ace_video_if;
  import ace_video_pkg::*;

  logic              ce_pix;
  logic              ce_pix_actual;
  logic              hs;
  logic              vs;
  logic              line_start;
  logic              hblank;
  logic              vblank;
  logic              de;
  logic [CNT_W-1:0]  hcnt;
  logic [CNT_W-1:0]  vcnt;
  logic              fetch;
  logic [ADDR_W-1:0] char_addr;
  logic [ROW_W-1:0]  char_row;

  modport master (
    output ce_pix, ce_pix_actual, hs, vs,
    output line_start, hblank, vblank, de,
    output hcnt, vcnt, fetch, char_addr, char_row
  );

  modport slave (
    input ce_pix, ce_pix_actual, hs, vs,
    input line_start, hblank, vblank, de,
    input hcnt, vcnt, fetch, char_addr, char_row
  );
endinterface

// File: rtl/ace_ce_gen.sv
// Clock divider: tick (comb, last div phase), registered ce_pix/ce_pix_actual.
// Ports: clk_sys, reset, odd_pix (next pixel is odd) -> tick, ce_pix, ce_pix_actual.
module ace_ce_gen #(
  parameter int CLK_DIV = 4,
  parameter bit PIX_REP = 1'b0
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic odd_pix,
  output logic tick,
  output logic ce_pix,
  output logic ce_pix_actual
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

  if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
    $error("CLK_DIV must be in 2..16");
  end

  logic [DW-1:0] div;

  assign tick = (div == DMAX);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div           <= '0;
      ce_pix        <= 1'b0;
      ce_pix_actual <= 1'b0;
    end else begin
      div           <= tick ? '0 : div + 1'b1;
      ce_pix        <= tick;
      ce_pix_actual <= tick & (~PIX_REP | ~odd_pix);
    end
  end
endmodule

// File: rtl/ace_video_timing.sv
// Native 15 kHz Jupiter Ace raster: beam counters, syncs, blanking, char fetch.
// Ports: clk_sys, reset (sync, active high), vid (ace_video_if.master).
import ace_video_pkg::*;

module ace_video_timing #(
  parameter int CLK_DIV      = 4,
  parameter bit PIX_REP      = 1'b0,
  parameter int H_TOTAL      = ACE_H_TOTAL,
  parameter int H_ACTIVE     = ACE_H_ACTIVE,
  parameter int H_SYNC_START = ACE_H_SYNC_START,
  parameter int H_SYNC_LEN   = ACE_H_SYNC_LEN,
  parameter int V_TOTAL      = ACE_V_TOTAL,
  parameter int V_ACTIVE     = ACE_V_ACTIVE,
  parameter int V_SYNC_START = ACE_V_SYNC_START,
  parameter int V_SYNC_LEN   = ACE_V_SYNC_LEN
) (
  input  logic        clk_sys,
  input  logic        reset,
  ace_video_if.master vid
);
  localparam int XW = CNT_W + 1;
  localparam logic [CNT_W-1:0] HMAX = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VMAX = CNT_W'(V_TOTAL - 1);
  localparam logic [XW-1:0] HA  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] VA  = XW'(V_ACTIVE);
  localparam logic [XW-1:0] HSS = XW'(H_SYNC_START);
  localparam logic [XW-1:0] HSE = XW'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [XW-1:0] VSS = XW'(V_SYNC_START);
  localparam logic [XW-1:0] VSE = XW'(V_SYNC_START + V_SYNC_LEN);

  if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_tot
    $error("raster totals exceed 9-bit counters");
  end
  if (H_ACTIVE > H_TOTAL || H_SYNC_START + H_SYNC_LEN > H_TOTAL)
  begin : g_bad_h
    $error("horizontal windows exceed H_TOTAL");
  end
  if (V_ACTIVE > V_TOTAL || V_SYNC_START + V_SYNC_LEN > V_TOTAL)
  begin : g_bad_v
    $error("vertical windows exceed V_TOTAL");
  end

  logic             tick;
  logic             h_wrap;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic [XW-1:0]    hx, vx;
  logic             act_nxt;

  ace_ce_gen #(
    .CLK_DIV (CLK_DIV),
    .PIX_REP (PIX_REP)
  ) u_ce (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .odd_pix       (h_nxt[0]),
    .tick          (tick),
    .ce_pix        (vid.ce_pix),
    .ce_pix_actual (vid.ce_pix_actual)
  );

  always_comb begin
    h_wrap = (hcnt == HMAX);
    h_nxt  = h_wrap ? '0 : hcnt + 1'b1;
    v_nxt  = vcnt;
    if (h_wrap)
      v_nxt = (vcnt == VMAX) ? '0 : vcnt + 1'b1;
    hx      = {1'b0, h_nxt};
    vx      = {1'b0, v_nxt};
    act_nxt = (hx < HA) && (vx < VA);
  end

  // Outputs are computed from the next counter values so they line up
  // with the ce_pix pulse issued on the same edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt           <= '0;
      vcnt           <= '0;
      vid.hs         <= 1'b0;
      vid.vs         <= 1'b0;
      vid.line_start <= 1'b0;
      vid.hblank     <= 1'b0;
      vid.vblank     <= 1'b0;
      vid.de         <= 1'b0;
      vid.fetch      <= 1'b0;
      vid.char_addr  <= '0;
      vid.char_row   <= '0;
    end else begin
      vid.fetch <= 1'b0;
      if (tick) begin
        hcnt           <= h_nxt;
        vcnt           <= v_nxt;
        vid.hs         <= in_win(hx, HSS, HSE);
        vid.vs         <= in_win(vx, VSS, VSE);
        vid.line_start <= (h_nxt == HMAX);
        vid.hblank     <= (hx >= HA);
        vid.vblank     <= (vx >= VA);
        vid.de         <= act_nxt;
        if (act_nxt && h_nxt[2:0] == 3'd0) begin
          vid.fetch     <= 1'b1;
          vid.char_addr <= {v_nxt[7:3], h_nxt[7:3]};
          vid.char_row  <= v_nxt[2:0];
        end
      end
    end
  end

  assign vid.hcnt = hcnt;
  assign vid.vcnt = vcnt;
endmodule

// File: tb/tb_ace_video_timing.sv
// Bench for ace_video_timing: arithmetic raster model plus directed checks.
// Three instances: Ace default, pixel-doubled, and a small raster for frames.
module tb_ace_video_timing;
  typedef struct {
    int cd, pr, ht, ha, hss, hsl, vt, va, vss, vsl;
  } cfg_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic armed   = 1'b0;
  int   k       = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  logic [9:0] ea [3];
  logic [2:0] er [3];

  always #5 clk_sys = ~clk_sys;

  ace_video_if v0();
  ace_video_if v1();
  ace_video_if v2();

  ace_video_timing #(.CLK_DIV(4)) d0 (
    .clk_sys (clk_sys), .reset (reset), .vid (v0)
  );
  ace_video_timing #(.CLK_DIV(2), .PIX_REP(1'b1)) d1 (
    .clk_sys (clk_sys), .reset (reset), .vid (v1)
  );
  ace_video_timing #(
    .CLK_DIV(2), .H_TOTAL(64), .H_ACTIVE(32),
    .H_SYNC_START(40), .H_SYNC_LEN(8),
    .V_TOTAL(40), .V_ACTIVE(24),
    .V_SYNC_START(30), .V_SYNC_LEN(4)
  ) d2 (
    .clk_sys (clk_sys), .reset (reset), .vid (v2)
  );

  function automatic cfg_t cfg_of(input int d);
    case (d)
      0: return '{4, 0, 416, 256, 320, 32, 312, 192, 248, 8};
      1: return '{2, 1, 416, 256, 320, 32, 312, 192, 248, 8};
      default: return '{2, 0, 64, 32, 40, 8, 40, 24, 30, 4};
    endcase
  endfunction

  function automatic logic [39:0] get(input int d);
    case (d)
      0: return {v0.ce_pix, v0.ce_pix_actual, v0.hs, v0.vs,
                 v0.line_start, v0.hblank, v0.vblank, v0.de,
                 v0.fetch, v0.hcnt, v0.vcnt, v0.char_addr, v0.char_row};
      1: return {v1.ce_pix, v1.ce_pix_actual, v1.hs, v1.vs,
                 v1.line_start, v1.hblank, v1.vblank, v1.de,
                 v1.fetch, v1.hcnt, v1.vcnt, v1.char_addr, v1.char_row};
      default:
         return {v2.ce_pix, v2.ce_pix_actual, v2.hs, v2.vs,
                 v2.line_start, v2.hblank, v2.vblank, v2.de,
                 v2.fetch, v2.hcnt, v2.vcnt, v2.char_addr, v2.char_row};
    endcase
  endfunction

  // k clocks since reset release: t = k/cd pixels elapsed, so the beam
  // sits at pixel t of the frame (row-major).
  function automatic logic [39:0] model(
    input cfg_t c, input int kk,
    input logic [9:0] a0, input logic [2:0] r0
  );
    int t, p, h, v;
    logic ce, cea, hs, vs, ls, hb, vb, de, fe;
    logic [9:0] a;
    logic [2:0] r;
    t = kk / c.cd;
    if (t == 0) return '0;
    ce  = (kk % c.cd) == 0;
    p   = t % (c.ht * c.vt);
    h   = p % c.ht;
    v   = p / c.ht;
    cea = ce && (c.pr == 0 || h % 2 == 0);
    hs  = h >= c.hss && h < c.hss + c.hsl;
    vs  = v >= c.vss && v < c.vss + c.vsl;
    ls  = h == c.ht - 1;
    hb  = h >= c.ha;
    vb  = v >= c.va;
    de  = !hb && !vb;
    fe  = ce && h % 8 == 0 && de;
    a   = a0;
    r   = r0;
    if (fe) begin
      a = 10'((v / 8) * 32 + h / 8);
      r = 3'(v % 8);
    end
    return {ce, cea, hs, vs, ls, hb, vb, de, fe,
            9'(h), 9'(v), a, r};
  endfunction

  task automatic chk(input string nm,
                     input logic [39:0] a, input logic [39:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    chk(nm, 40'(a), 40'(e));
  endtask

  task automatic wait_pix(input int d, input int h, input int v,
                          input int budget, input string nm);
    logic [39:0] o;
    int n;
    n = 0;
    o = get(d);
    while (!(o[39] && int'(o[30:22]) == h &&
             (v < 0 || int'(o[21:13]) == v)) && n < budget) begin
      @(negedge clk_sys);
      o = get(d);
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout after %0d clocks", nm, n);
    end
  endtask

  always @(posedge clk_sys) k <= reset ? 0 : k + 1;

  always @(negedge clk_sys) begin
    if (armed) begin
      for (int d = 0; d < 3; d++) begin
        logic [39:0] e;
        if (k == 0) begin
          ea[d] = '0;
          er[d] = '0;
        end
        e = model(cfg_of(d), k, ea[d], er[d]);
        ea[d] = e[12:3];
        er[d] = e[2:0];
        chk($sformatf("cyc_d%0d", d), get(d), e);
      end
    end
  end

  initial begin
    int nce, hsr, hsf, hsn, lsc, lsh, hbr, ov, nf, nca, vsl, vbl;
    int lh, lv;
    logic hp, hbp;

    repeat (3) @(negedge clk_sys);
    armed = 1'b1;
    chk("rst_all", get(0), 40'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    chki("ce_before_4", int'(v0.ce_pix), 0);
    @(negedge clk_sys);
    chki("first_ce", int'(v0.ce_pix), 1);
    chki("first_hcnt", int'(v0.hcnt), 1);

    wait_pix(0, 0, -1, 2000, "sync_line");
    nce = 0; hsr = -1; hsf = -1; hsn = 0; lsc = 0;
    lsh = -1; hbr = -1; ov = 0; hp = 1'b0; hbp = 1'b0;
    repeat (1664) begin
      @(negedge clk_sys);
      if (v0.ce_pix) begin
        nce++;
        if (v0.hs && !hp) hsr = int'(v0.hcnt);
        if (!v0.hs && hp) hsf = int'(v0.hcnt);
        if (v0.hs) hsn++;
        if (v0.hblank && !hbp) hbr = int'(v0.hcnt);
        hp  = v0.hs;
        hbp = v0.hblank;
      end
      if (v0.line_start) begin
        lsc++;
        lsh = int'(v0.hcnt);
      end
      if (v0.hs && v0.line_start) ov++;
    end
    chki("ce_per_line", nce, 416);
    chki("hs_rise", hsr, 320);
    chki("hs_fall", hsf, 352);
    chki("hs_width", hsn, 32);
    chki("ls_clocks", lsc, 4);
    chki("ls_hcnt", lsh, 415);
    chki("hblank_rise", hbr, 256);
    chki("hs_ls_overlap", ov, 0);

    wait_pix(0, 0, 13, 22000, "sync_v13");
    nf = 0;
    repeat (1664) begin
      if (v0.fetch) begin
        chki($sformatf("addr_%0d", nf), int'(v0.char_addr), 32 + nf);
        chki($sformatf("row_%0d", nf), int'(v0.char_row), 5);
        nf++;
      end
      @(negedge clk_sys);
    end
    chki("fetch_v13", nf, 32);

    nce = 0; nca = 0;
    repeat (832) begin
      @(negedge clk_sys);
      if (v1.ce_pix) nce++;
      if (v1.ce_pix_actual) nca++;
    end
    chki("rep_ce", nce, 416);
    chki("rep_ce_actual", nca, 208);

    wait_pix(2, 0, 0, 6000, "sync_frame");
    nce = 0; vsl = 0; vbl = 0; nf = 0; lh = -1; lv = -1;
    repeat (5120) begin
      if (v2.ce_pix) begin
        nce++;
        lh = int'(v2.hcnt);
        lv = int'(v2.vcnt);
        if (v2.hcnt == 9'd0 && v2.vs) vsl++;
        if (v2.hcnt == 9'd0 && v2.vblank) vbl++;
      end
      if (v2.fetch) nf++;
      @(negedge clk_sys);
    end
    chki("frame_ce", nce, 2560);
    chki("vs_lines", vsl, 4);
    chki("vblank_lines", vbl, 16);
    chki("frame_fetch", nf, 96);
    chki("wrap_from_h", lh, 63);
    chki("wrap_from_v", lv, 39);
    chki("wrap_to_h", int'(v2.hcnt), 0);
    chki("wrap_to_v", int'(v2.vcnt), 0);

    wait_pix(0, 330, -1, 2000, "sync_h330");
    chki("pre_rst_hs", int'(v0.hs), 1);
    reset = 1'b1;
    @(negedge clk_sys);
    chki("rst_hs", int'(v0.hs), 0);
    chki("rst_hcnt", int'(v0.hcnt), 0);
    chki("rst_vcnt", int'(v0.vcnt), 0);
    chki("rst_ce", int'(v0.ce_pix), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    chki("re_ce_before_4", int'(v0.ce_pix), 0);
    @(negedge clk_sys);
    chki("re_first_ce", int'(v0.ce_pix), 1);
    chki("re_first_hcnt", int'(v0.hcnt), 1);
    repeat (8) @(negedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
